// File: rtl/serial_pkg.sv
// Shared definitions for the host serial link: FSM state encoding and the bit-period derivation.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } serial_state_t;

    function automatic int clks_per_bit(input int clock_frequency, input int baudrate);
        return clock_frequency / baudrate;
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period counter 0..CLKS_PER_BIT-1; tick is a same-cycle strobe on the last count.
// No backpressure; a synchronous clear holds the count at zero and suppresses tick.
module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter, 8 data bits LSB first, one stop bit; even parity when SERIAL_TX_PARITY_EN is defined.
// Start bit leaves the cycle after the transfer edge; o_Tx_Ready is low for the whole frame and i_Tx_DV is dropped meanwhile.
module serial_tx
    import serial_pkg::*;
#(
    parameter int BAUDRATE        = 115200,
    parameter int CLOCK_FREQUENCY = 48000000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUDRATE);

    serial_state_t state;
    logic [7:0]    shift;
    logic [2:0]    bit_index;
    logic          tick;
    logic          clear;
`ifdef SERIAL_TX_PARITY_EN
    logic          parity;
`endif

    // The bit period restarts from zero on every transfer edge.
    assign clear = (state == ST_IDLE) || (state == ST_CLEANUP);

    serial_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .clear  (clear),
        .tick   (tick)
    );

    // Outputs are registered on the edge that changes state, so the line
    // reflects the new bit one cycle after that edge.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_index   <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Ready  <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Ready  <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    if (i_Tx_DV && o_Tx_Ready) begin
                        shift       <= i_Tx_Byte;
                        bit_index   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        parity      <= ^i_Tx_Byte;
`endif
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Ready  <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        o_Tx_Serial <= shift[0];
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_index == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            o_Tx_Serial <= parity;
                            state       <= ST_PARITY;
`else
                            o_Tx_Serial <= 1'b1;
                            state       <= ST_STOP;
`endif
                        end else begin
                            bit_index   <= bit_index + 3'd1;
                            shift       <= {1'b0, shift[7:1]};
                            o_Tx_Serial <= shift[1];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        o_Tx_Serial <= 1'b1;
                        state       <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        o_Tx_Done   <= 1'b1;
                        o_Tx_Active <= 1'b0;
                        state       <= ST_CLEANUP;
                    end
                end
                ST_CLEANUP: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Ready  <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Ready  <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at N=4 clocks per bit; cycle c is the value seen just before rising edge c.
module tb_serial_tx;

    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int DONE_C = FB * N + 1;

    logic       i_Clock   = 1'b0;
    logic       i_Reset   = 1'b0;
    logic       i_Tx_DV   = 1'b0;
    logic [7:0] i_Tx_Byte = 8'h00;
    logic       o_Tx_Serial;
    logic       o_Tx_Ready;
    logic       o_Tx_Active;
    logic       o_Tx_Done;

    int errors = 0;
    int checks = 0;

    serial_tx #(
        .BAUDRATE       (250000),
        .CLOCK_FREQUENCY(1000000)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Tx_DV    (i_Tx_DV),
        .i_Tx_Byte  (i_Tx_Byte),
        .o_Tx_Serial(o_Tx_Serial),
        .o_Tx_Ready (o_Tx_Ready),
        .o_Tx_Active(o_Tx_Active),
        .o_Tx_Done  (o_Tx_Done)
    );

    always #5 i_Clock = ~i_Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Line bits in transmit order: start, d0..d7, [parity], stop, then idle.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_Clock);
            if (o_Tx_Ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] obs;
        @(negedge i_Clock);
        #2 i_Reset = 1'b1;
        #1 obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL reset_async: got srad=%b want 1100", obs);
        end
        repeat (3) @(negedge i_Clock);
        obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL reset_held: got srad=%b want 1100", obs);
        end
        i_Reset = 1'b0;
        repeat (3) @(negedge i_Clock);
        obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle: got srad=%b want 1100", obs);
        end
    endtask

    // One frame; poke pulses i_Tx_DV with 0x3C mid-frame, which must be ignored.
    task automatic test_send(input string name, input logic [7:0] b, input bit poke);
        logic [10:0] f;
        logic [3:0]  obs;
        logic [3:0]  exp;
        logic        el;
        bit          ok;
        f = frame_of(b);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_ready_wait: got ready=%b want 1", name, o_Tx_Ready);
        end
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = b;
        @(posedge i_Clock);
        for (int c = 1; c <= DONE_C + 8; c++) begin
            @(negedge i_Clock);
            el  = (c <= FB * N) ? f[(c - 1) / N] : 1'b1;
            exp = {el, c > DONE_C, c <= FB * N, c == DONE_C};
            obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got srad=%b want %b", name, c, obs, exp);
            end
            if (c == 1) begin
                i_Tx_DV   = 1'b0;
                i_Tx_Byte = ~b;
            end
            if (poke && c == 10) begin
                i_Tx_DV   = 1'b1;
                i_Tx_Byte = 8'h3C;
            end
            if (poke && c == 11) begin
                i_Tx_DV   = 1'b0;
                i_Tx_Byte = 8'hC3;
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int O = DONE_C + 1;
        logic [10:0] f1;
        logic [10:0] f2;
        logic [3:0]  obs;
        logic [3:0]  exp;
        logic        el;
        logic        ea;
        bit          ok;
        f1 = frame_of(8'h00);
        f2 = frame_of(8'hFF);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_ready_wait: got ready=%b want 1", o_Tx_Ready);
        end
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h00;
        @(posedge i_Clock);
        for (int c = 1; c <= O + DONE_C + 2; c++) begin
            @(negedge i_Clock);
            el = 1'b1;
            ea = 1'b0;
            if (c <= FB * N) begin
                el = f1[(c - 1) / N];
                ea = 1'b1;
            end else if (c > O && c <= O + FB * N) begin
                el = f2[(c - O - 1) / N];
                ea = 1'b1;
            end
            exp = {el, (c == O) || (c > O + DONE_C), ea, (c == DONE_C) || (c == O + DONE_C)};
            obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got srad=%b want %b", c, obs, exp);
            end
            if (c == 1) i_Tx_Byte = 8'hFF;
            if (c == O + 1) begin
                i_Tx_DV   = 1'b0;
                i_Tx_Byte = 8'h11;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] obs;
        bit         ok;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_ready_wait: got ready=%b want 1", o_Tx_Ready);
        end
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h00;
        @(posedge i_Clock);
        for (int c = 1; c <= 17; c++) begin
            @(negedge i_Clock);
            if (c == 1) i_Tx_DV = 1'b0;
        end
        // Cycle 17 is inside data bit 3, which is 0 for this byte.
        checks++;
        if (o_Tx_Serial !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bit3: got line=%b want 0", o_Tx_Serial);
        end
        #2 i_Reset = 1'b1;
        #1 obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_async: got srad=%b want 1100", obs);
        end
        @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (2) @(negedge i_Clock);
        obs = {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_release: got srad=%b want 1100", obs);
        end
    endtask

    initial begin
        test_reset();
        test_send("send_a5", 8'hA5, 1'b0);
        test_back_to_back();
        test_send("ignore_busy_5a", 8'h5A, 1'b1);
        test_reset_mid();
        test_send("after_reset_81", 8'h81, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        test_send("parity_07", 8'h07, 1'b0);
        test_send("parity_03", 8'h03, 1'b0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
